// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'b1111;
  localparam int         KEY_W     = 4;

  // Lowest-numbered active-low column; only meaningful when col != COL_IDLE.
  function automatic logic [1:0] lowest_zero(input logic [3:0] col);
    if (!col[0])      return 2'd0;
    else if (!col[1]) return 2'd1;
    else if (!col[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle scan tick every CLK_DIV clocks.
module scan_tick_gen
  import keypad_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic clk_50M,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50M) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: row rotation, column sync, debounce, one code per press.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic [3:0]       COL,
  output logic [3:0]       ROW,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int CNT_MAX_A = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS : REPEAT_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             tick;
  logic [3:0]       col_s1, col_s2;
  state_t           state;
  logic [1:0]       r, c;
  logic [CNT_W-1:0] cnt;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_TGT = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_TGT = CNT_W'(REPEAT_PERIOD);
  logic [CNT_W-1:0] rep_cnt;
  logic             rep_phase;
`endif

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_50M (clk_50M),
    .rst     (rst),
    .tick    (tick)
  );

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      col_s1    <= COL_IDLE;
      col_s2    <= COL_IDLE;
      state     <= SCAN;
      r         <= 2'd0;
      c         <= 2'd0;
      cnt       <= '0;
      ROW       <= ROW_RESET;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      col_s1    <= COL;
      col_s2    <= col_s1;
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (col_s2 != COL_IDLE) begin
              c     <= lowest_zero(col_s2);
              cnt   <= '0;
              state <= DEBOUNCE;
            end else begin
              r   <= r + 2'd1;
              ROW <= row_drive(r + 2'd1);
            end
          end
          DEBOUNCE: begin
            if (!col_s2[c]) begin
              if (cnt == DB_LAST) begin
                state     <= PRESSED;
                key_code  <= {r, c};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt   <= '0;
                rep_phase <= 1'b0;
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= SCAN;
              r     <= r + 2'd1;
              ROW   <= row_drive(r + 2'd1);
            end
          end
          PRESSED: begin
            if (col_s2[c]) begin
              cnt   <= '0;
              state <= RELEASE;
            end
`ifdef KEYPAD_REPEAT_EN
            // Repeat counter survives a RELEASE bounce; it only clears on a fresh accept.
            else if (CNT_W'(rep_cnt + 1'b1) == (rep_phase ? RP_TGT : RD_TGT)) begin
              key_valid <= 1'b1;
              rep_cnt   <= '0;
              rep_phase <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
`endif
          end
          RELEASE: begin
            if (col_s2[c]) begin
              if (cnt == DB_LAST) begin
                key_held <= 1'b0;
                state    <= SCAN;
                r        <= r + 2'd1;
                ROW      <= row_drive(r + 2'd1);
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= PRESSED;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed and randomized key presses against a keypad model.
module tb_keypad_scanner;

  localparam int CLK_DIV = 4;
  localparam int DB      = 3;
  localparam int RD      = 5;
  localparam int RP      = 2;
  localparam int BOUND   = 100;

  logic       clk_50M = 1'b0;
  logic       rst;
  logic [3:0] COL, ROW, key_code;
  logic       key_valid, key_held;

  keypad_scanner #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .COL      (COL),
    .ROW      (ROW),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #10 clk_50M = ~clk_50M;

  // Physical keypad: a pressed key shorts its column low while its row is driven.
  logic [15:0] pressed;
  logic [3:0]  bounce_low, glitch_high;
  always_comb begin
    COL = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      if (!ROW[rr])
        for (int cc = 0; cc < 4; cc++)
          if (pressed[rr*4+cc]) COL[cc] = 1'b0;
    COL = (COL | glitch_high) & ~bounce_low;
  end

  int          cyc = 0, pulses = 0, long_pulse = 0;
  logic        prev_valid = 1'b0;
  int          pulse_cyc[$];
  logic [3:0]  pulse_code[$];

  always @(negedge clk_50M) begin
    cyc <= cyc + 1;
    prev_valid <= key_valid;
    if (key_valid) begin
      pulses <= pulses + 1;
      pulse_cyc.push_back(cyc);
      pulse_code.push_back(key_code);
      if (prev_valid) long_pulse <= long_pulse + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_50M);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * CLK_DIV) step();
  endtask

  task automatic wait_pulses(input int target, input string tag);
    int k = 0;
    while (pulses < target && k < BOUND) begin step(); k++; end
    check({tag, "_pulse_timeout"}, 32'(pulses >= target), 1);
  endtask

  task automatic wait_release(input string tag);
    int k = 0;
    while (key_held && k < BOUND) begin step(); k++; end
    check({tag, "_release_timeout"}, 32'(key_held), 0);
  endtask

  function automatic logic [3:0] exp_row(input int r);
    logic [3:0] one = 4'b0001;
    return ~(one << (r % 4));
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r, c, h, idx;
    logic [3:0] row_before;
    logic [15:0] keys;

    rst = 1'b1; pressed = '0; bounce_low = '0; glitch_high = '0;
    repeat (3) step();
    check("rst_row", ROW, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    rst = 1'b0;

    // Idle scanning: exactly one row driven at a time, rotating in order.
    for (int i = 1; i <= 6; i++) begin
      wait_ticks(1);
      check("scan_onehot", $countones(~ROW), 1);
      check("scan_order", ROW, exp_row(i));
    end

    // Reset mid-scan.
    rst = 1'b1; step();
    check("midrst_row", ROW, 4'b1110);
    check("midrst_code", key_code, 0);
    check("midrst_valid", key_valid, 0);
    check("midrst_held", key_held, 0);
    rst = 1'b0;

    // Clean press of row 2, col 1.
    base = pulses;
    pressed[9] = 1'b1;
    wait_pulses(base + 1, "clean");
    check("clean_code", key_code, 9);
    check("clean_held", key_held, 1);
    wait_ticks(2);
    check("clean_hold_nopulse", pulses, base + 1);
    check("clean_hold_held", key_held, 1);
    pressed = '0;
    wait_release("clean");
    check("clean_row_resume", ROW, 4'b0111);
    check("clean_single_pulse", pulses, base + 1);

    // Repeated one-tick bounces on col 0.
    base = pulses;
    for (int i = 0; i < 3; i++) begin
      bounce_low = 4'b0001;
      repeat (CLK_DIV) step();
      bounce_low = 4'b0000;
      wait_ticks(6);
      row_before = ROW;
      wait_ticks(1);
      check("bounce_rotating", 32'(ROW != row_before), 1);
    end
    check("bounce_nopulse", pulses, base);
    check("bounce_held", key_held, 0);

    // Two keys on row 1 (cols 3 and 2), then an extra key on row 3 while held.
    base = pulses;
    pressed[7] = 1'b1; pressed[6] = 1'b1;
    wait_pulses(base + 1, "two");
    check("two_code", key_code, 6);
    pressed[13] = 1'b1;
    wait_ticks(2);
    check("two_extra_nopulse", pulses, base + 1);
    check("two_extra_held", key_held, 1);
    pressed = '0;
    wait_release("two");
    check("two_row_resume", ROW, 4'b1011);

    // One-tick release glitch while held.
    base = pulses;
    pressed[0] = 1'b1;
    wait_pulses(base + 1, "glitch");
    check("glitch_code", key_code, 0);
    repeat (2) step();
    glitch_high = 4'b0001;
    repeat (CLK_DIV) step();
    glitch_high = 4'b0000;
    h = 1;
    repeat (CLK_DIV + 4) begin step(); h &= int'(key_held); end
    check("glitch_held_stays", h, 1);
    check("glitch_nopulse", pulses, base + 1);
    pressed = '0;
    wait_release("glitch");
    check("glitch_row_resume", ROW, 4'b1101);

    // Randomized presses; lowest column on the row wins.
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      keys = '0;
      keys[r*4+c] = 1'b1;
      for (int cc = c + 1; cc < 4; cc++) if ($urandom_range(0, 1) == 1) keys[r*4+cc] = 1'b1;
      base = pulses;
      pressed = keys;
      wait_pulses(base + 1, "rand");
      check("rand_code", key_code, r * 4 + c);
      check("rand_held", key_held, 1);
      wait_ticks(int'($urandom_range(0, 2)));
      pressed = '0;
      wait_release("rand");
      check("rand_single_pulse", pulses, base + 1);
      check("rand_row_resume", ROW, exp_row(r + 1));
      wait_ticks(int'($urandom_range(1, 5)));
    end

    // Reset while a key is held discards it.
    base = pulses;
    pressed[5] = 1'b1;
    wait_pulses(base + 1, "hrst");
    check("hrst_code_before", key_code, 5);
    rst = 1'b1; step();
    check("hrst_row", ROW, 4'b1110);
    check("hrst_code", key_code, 0);
    check("hrst_held", key_held, 0);
    check("hrst_valid", key_valid, 0);
    pressed = '0;
    step();
    rst = 1'b0;
    wait_ticks(4);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: pulses at accept, +RD, then every RP ticks while held.
    base = pulses;
    pressed[14] = 1'b1;
    wait_pulses(base + 1, "rep");
    idx = base;
    wait_ticks(12);
    pressed = '0;
    wait_release("rep");
    check("rep_count", pulses - base, 5);
    if (pulse_cyc.size() >= idx + 5) begin
      check("rep_first_gap", pulse_cyc[idx+1] - pulse_cyc[idx], RD * CLK_DIV);
      for (int k = 2; k < 5; k++)
        check("rep_period_gap", pulse_cyc[idx+k] - pulse_cyc[idx+k-1], RP * CLK_DIV);
      for (int k = 0; k < 5; k++) check("rep_code", pulse_code[idx+k], 14);
    end
`endif

    check("pulse_width_one_cycle", long_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the dynamic-scan display driver: scans a 4x4 active-low matrix keypad by rotating row drive, samples the columns, debounces, and emits one key code per press.
- Sits between board keypad pins and control logic, e.g. the counter/foul logic that feeds the display. Shares the 50 MHz board clock.

Parameters:
- CLK_DIV, 50000, clk_50M cycles per scan tick (1 kHz at 50 MHz); minimum 4.
- DEBOUNCE_TICKS, 20, consecutive stable ticks required to accept a press or a release; minimum 1.
- REPEAT_DELAY, 500, ticks held before first auto-repeat (optional feature only).
- REPEAT_PERIOD, 100, ticks between auto-repeats (optional feature only).

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  synchronous active-high reset.
- COL  in  4  keypad columns, active low, externally pulled up, asynchronous.
- ROW  out  4  keypad row drive, active low, one-hot-zero.
- key_code  out  4  last accepted key, row*4+col.
- key_valid  out  1  one-cycle pulse when key_code is updated.
- key_held  out  1  high while an accepted key remains pressed.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk_50M and rst.
- Reset values: ROW=4'b1110 (row 0), key_code=0, key_valid=0, key_held=0, FSM=SCAN, tick and debounce counters=0.
- COL passes through a 2-flop synchronizer before use. colS denotes the synchronized value.
- Tick: a free-running counter 0..CLK_DIV-1. tick=1 for one cycle at CLK_DIV-1. All FSM actions occur only on tick cycles.
- ROW changes only on a tick, so each row has a full tick period to settle before it is sampled.
- Row index r (0..3): ROW = ~(1<<r). Captured column c is the lowest index with colS[c]==0.
- SCAN:
  - On tick, if colS != 4'b1111: capture r and c, clear cnt, go to DEBOUNCE. ROW holds.
  - Otherwise r advances by 1 with wrap 3->0.
- DEBOUNCE:
  - On tick, if colS[c]==0: cnt++. When cnt reaches DEBOUNCE_TICKS-1, go to PRESSED, set key_code={r,c}, pulse key_valid, set key_held=1.
  - On tick, if colS[c]==1 (bounce): go to SCAN and advance r. No output.
- PRESSED:
  - ROW holds on r.
  - On tick, if colS[c]==1: cnt=0 and go to RELEASE.
  - Other keys pressed meanwhile are ignored; there is no rollover.
- RELEASE:
  - On tick, if colS[c]==1: cnt++. When cnt reaches DEBOUNCE_TICKS-1, set key_held=0, go to SCAN, advance r.
  - On tick, if colS[c]==0: return to PRESSED with no new key_valid.
- key_valid is exactly one clk_50M cycle, coincident with the key_code update. key_code holds its value until the next accepted press.
- Latency: press to key_valid is at most 4 + DEBOUNCE_TICKS ticks, plus 2 cycles of sync delay.
- Simultaneous keys on the scanned row: the lowest column wins.
- rst asserted in any state returns all outputs to their reset values on the next edge. An in-flight press is discarded.
- Counter widths: the tick counter is $clog2(CLK_DIV). The debounce/repeat counter is sized for max(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_PERIOD).

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in PRESSED, a second counter counts ticks. After REPEAT_DELAY ticks, key_valid pulses with unchanged key_code, then pulses again every REPEAT_PERIOD ticks until leaving PRESSED. The counter clears on entering PRESSED. A bounce into RELEASE and back does not clear it.
- Undefined: one key_valid per press. The REPEAT_* parameters are unused and add no logic.

Decomposition:
- Package keypad_pkg:
  - FSM state enum {SCAN, DEBOUNCE, PRESSED, RELEASE}.
  - ROW_RESET = 4'b1110.
  - COL_IDLE = 4'b1111.
  - KEY_W = 4.
- Sub-module scan_tick_gen(clk_50M, rst, tick): parameterized by CLK_DIV, generates the one-cycle tick.

Test Plan:
- Reset with CLK_DIV=4, DEBOUNCE_TICKS=3: assert rst mid-scan -> next cycle ROW=1110, key_code=0, key_valid=0, key_held=0.
- Clean press of key at row 2, col 1 (COL[1]=0 only while ROW=1011) -> one key_valid pulse with key_code=9, key_held=1 until release is debounced, then ROW resumes rotating from row 3.
- Bounce: hold col 0 low for 1 tick then release, repeated -> no key_valid, FSM returns to SCAN each time.
- Two keys pressed at row 1, cols 3 and 2 -> key_code=6. A later extra press at row 3 while held -> no new pulse.
- Release glitch: a 1-tick high on the held column during PRESSED -> returns to PRESSED, no second key_valid, key_held stays 1.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=5, REPEAT_PERIOD=2, key held 12 ticks after acceptance -> pulses at accept, +5, +7, +9 and +11 ticks, each with the same key_code.
